serial_paralelo_rx: RTL and testbench

Receive-side serial-to-parallel converter. It sits directly downstream of the TX parallel-to-serial stage, on the same `clk_32f` serial bit clock. It hunts the incoming MSB-first bit stream for the COM symbol (8'hBC) to find byte alignment, then confirms alignment over consecutive COM symbols. After that it delivers each recovered byte with a valid qualifier: data bytes are valid, COM/idle bytes are not.

---
 rtl/pcie_phy_pkg.sv | 14 +
 rtl/com_detector.sv | 30 +++
 rtl/serial_paralelo_rx.sv | 126 ++++++++++++
 tb/tb_serial_paralelo_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PHY definitions: alignment symbol, receiver state encoding and lock defaults.
package pcie_phy_pkg;

  localparam logic [7:0] COM = 8'hBC;

  localparam int unsigned SyncCountDefault = 4;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StSync   = 2'd1,
    StActive = 2'd2
  } rx_state_e;

endpackage

// File: rtl/com_detector.sv
// Serial shift register with a same-cycle COM compare on the incoming window.
module com_detector
  import pcie_phy_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_i,
  output logic [7:0] nxt_o,
  output logic       is_com_o
);

  logic [7:0] sr_q, sr_d;

  // The window including the bit being sampled now drives all decisions this cycle.
  always_comb begin
    sr_d = {sr_q[6:0], data_i};
  end

  assign nxt_o    = sr_d;
  assign is_com_o = (sr_d == COM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: hunts for COM, confirms byte alignment, then emits
// bytes with a valid qualifier (COM/idle bytes are reported as not valid).
module serial_paralelo_rx
  import pcie_phy_pkg::*;
#(
  parameter int unsigned SYNC_COUNT = SyncCountDefault
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [2:0] SyncCnt = 3'(SYNC_COUNT);

  rx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] com_cnt_q, com_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;

  logic [7:0] nxt;
  logic       is_com;
  logic       boundary;

  com_detector u_com_detector (
    .clk_i    (clk_32f),
    .rst_ni   (reset),
    .data_i   (data_in),
    .nxt_o    (nxt),
    .is_com_o (is_com)
  );

  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    active_d  = active_q;

    unique case (state_q)
      StHunt: begin
        bit_cnt_d = 3'd0;
        // Bit-level sliding search; the detection edge defines the byte phase.
        if (is_com) begin
          com_cnt_d = 3'd1;
          if (SyncCnt == 3'd1) begin
            state_d  = StActive;
            active_d = 1'b1;
          end else begin
            state_d = StSync;
          end
        end
      end

      StSync: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          data_d   = nxt;
          if (is_com) begin
            if (com_cnt_q + 3'd1 >= SyncCnt) begin
              com_cnt_d = SyncCnt;
              state_d   = StActive;
              active_d  = 1'b1;
            end else begin
              com_cnt_d = com_cnt_q + 3'd1;
            end
          end else begin
            com_cnt_d = 3'd0;
            bit_cnt_d = 3'd0;
            state_d   = StHunt;
          end
        end
      end

      StActive: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          data_d   = nxt;
          valid_d  = !is_com;
        end
      end

      default: begin
        state_d = StHunt;
      end
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q   <= StHunt;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx: directed vectors, corner sequences,
// randomized streams against a reference model, and an emulated TX idle/data stream.
module tb_serial_paralelo_rx;

  localparam logic [7:0] ComSym = 8'hBC;
  localparam int SyncN = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int checks   = 0;
  int failures = 0;

  serial_paralelo_rx #(
    .SYNC_COUNT (SyncN)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model: alignment is remembered as the cycle number of the first COM
  // hit; byte boundaries are every 8th cycle after that.
  int         m_t, m_t0, m_ncom;
  bit         m_aligned, m_active, m_valid, m_strobe;
  logic [7:0] m_hist, m_data;

  bit         collect = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  typedef struct {
    logic [7:0] byte_in;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_t0 = 0; m_ncom = 0;
    m_aligned = 0; m_active = 0; m_valid = 0; m_strobe = 0;
    m_hist = '0; m_data = '0;
  endtask

  task automatic model_step(input logic b);
    m_hist   = {m_hist[6:0], b};
    m_t++;
    m_strobe = 0;
    if (!m_aligned) begin
      if (m_hist == ComSym) begin
        m_aligned = 1; m_t0 = m_t; m_ncom = 1;
        if (SyncN == 1) m_active = 1;
      end
    end else if ((m_t - m_t0) % 8 == 0) begin
      m_strobe = 1;
      m_data   = m_hist;
      if (m_active) begin
        m_valid = (m_hist != ComSym);
      end else if (m_hist == ComSym) begin
        m_ncom++;
        if (m_ncom >= SyncN) m_active = 1;
      end else begin
        m_aligned = 0; m_ncom = 0;
      end
    end
  endtask

  task automatic post_edge(input logic b);
    model_step(b);
    #1;
    check("cycle_model", {21'd0, data_out, valid_out, byte_strobe, active},
          {21'd0, m_data, m_valid, m_strobe, m_active});
    if (collect && byte_strobe && valid_out) rx_q.push_back(data_out);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    post_edge(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic release_reset();
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clk_32f);
    post_edge(1'b0);
  endtask

  // Asserted mid-cycle so the clear must come from the asynchronous path.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_outputs", {21'd0, data_out, valid_out, byte_strobe, active}, 32'd0);
    repeat (2) @(posedge clk_32f);
  endtask

  initial begin
    vecs[0] = '{8'h5A, 8'h5A, 1'b1};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1};
    vecs[2] = '{8'hBC, 8'hBC, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b1};
    vecs[4] = '{8'h0B, 8'h0B, 1'b1};
    vecs[5] = '{8'hC0, 8'hC0, 1'b1};

    model_reset();
    repeat (2) @(posedge clk_32f);
    #1;
    check("reset_data_out", {24'd0, data_out}, 32'd0);
    check("reset_flags", {29'd0, valid_out, byte_strobe, active}, 32'd0);

    // Lock on a COM stream at bit offset 3.
    release_reset();
    send_bit(1'b0);
    send_bit(1'b0);
    send_byte(ComSym);
    check("first_com_no_strobe", {31'd0, byte_strobe}, 32'd0);
    for (int k = 2; k <= 4; k++) begin
      send_byte(ComSym);
      check("sync_strobe", {31'd0, byte_strobe}, 32'd1);
      check("sync_active", {31'd0, active}, (k == 4) ? 32'd1 : 32'd0);
      check("sync_valid", {31'd0, valid_out}, 32'd0);
    end

    // Data in ACTIVE, including a COM straddling 0B/C0.
    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].byte_in);
      check("tbl_strobe", {31'd0, byte_strobe}, 32'd1);
      check("tbl_data", {24'd0, data_out}, {24'd0, vecs[i].exp_data});
      check("tbl_valid", {31'd0, valid_out}, {31'd0, vecs[i].exp_valid});
    end
    check("straddle_active", {31'd0, active}, 32'd1);

    // Reset mid-byte in ACTIVE, then relock on fresh COMs.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    async_reset();
    release_reset();
    repeat (4) send_bit(1'b0);
    for (int k = 1; k <= 4; k++) begin
      send_byte(ComSym);
      check("relock_active", {31'd0, active}, (k == 4) ? 32'd1 : 32'd0);
    end

    // Non-COM during SYNC drops back to HUNT.
    @(posedge clk_32f);
    async_reset();
    release_reset();
    send_bit(1'b0);
    send_byte(ComSym);
    send_byte(ComSym);
    send_byte(8'h3C);
    check("sync_break_data", {24'd0, data_out}, 32'h3C);
    check("sync_break_strobe", {31'd0, byte_strobe}, 32'd1);
    check("sync_break_active", {31'd0, active}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      send_byte(ComSym);
      check("after_break_active", {31'd0, active}, (k == 4) ? 32'd1 : 32'd0);
    end

    // Randomized streams with random bit phase and noise.
    for (int r = 0; r < 4; r++) begin
      @(posedge clk_32f);
      async_reset();
      release_reset();
      for (int i = 0; i < int'($urandom_range(12, 0)); i++) send_bit(1'($urandom));
      for (int i = 0; i < 6; i++) send_byte(ComSym);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(9, 0) < 3) send_byte(ComSym);
        else send_byte(8'($urandom));
      end
    end

    // Emulated TX: zeros then idle COMs from arbitrary phase, then toggling valid data.
    @(posedge clk_32f);
    async_reset();
    release_reset();
    for (int i = 0; i < int'($urandom_range(7, 0)); i++) send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_byte(ComSym);
    check("chain_locked", {31'd0, active}, 32'd1);
    collect = 1'b1;
    begin
      int idx = 0;
      for (int s = 0; s < 40; s++) begin
        if ((s % 2 == 0) || ($urandom_range(1, 0) == 1)) begin
          logic [7:0] b;
          b = 8'h11 + 8'(idx % 8);
          idx++;
          tx_q.push_back(b);
          send_byte(b);
        end else begin
          send_byte(ComSym);
        end
      end
    end
    collect = 1'b0;
    check("chain_count", rx_q.size(), tx_q.size());
    for (int i = 0; i < tx_q.size() && i < rx_q.size(); i++) begin
      check("chain_byte", {24'd0, rx_q[i]}, {24'd0, tx_q[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
